// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction fetch (F)
// stage and the data memory (M) stage. One transaction is outstanding at a
// time. A per-transaction watchdog aborts requests the memory never completes.
//
// Optional feature macro: ARB_RR_EN
//   defined   : a last-grant register breaks ties in favour of the requester
//               that was not granted last (fetch cannot be starved by M).
//   undefined : fixed priority, dm always wins a tie.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   if_req     in   fetch request, held with if_addr until if_valid
//   if_addr    in   fetch address
//   if_rdata   out  fetch read data (0 unless if_valid)
//   if_valid   out  fetch completion pulse
//   dm_req     in   data request, held with dm_we/dm_addr/dm_wdata until dm_valid
//   dm_we      in   1 = write, 0 = read
//   dm_addr    in   data address
//   dm_wdata   in   data write data
//   dm_rdata   out  data read data (0 unless dm_valid)
//   dm_valid   out  data completion pulse (reads and writes)
//   mem_req    out  memory transaction active
//   mem_we     out  memory write enable (registered)
//   mem_addr   out  memory address (registered)
//   mem_wdata  out  memory write data (registered)
//   mem_rdata  in   memory read data, valid with mem_ready
//   mem_ready  in   memory completion strobe
//   StallF     out  if_req & ~if_valid
//   StallM     out  dm_req & ~dm_valid
//   err        out  watchdog abort pulse
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  StallF,
    output logic                  StallM,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    // Last count value a transaction may reach before being aborted.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic busy;
    logic timeout;
    logic done;
    logic cand_if;
    logic cand_dm;
    logic tie_dm;
    logic grant_if;
    logic grant_dm;

`ifdef ARB_RR_EN
    // 1 = dm was granted last, 0 = fetch was granted last (reset: fetch).
    logic last_dm_q, last_dm_d;
`endif

    // -------------------------------------------------------------------------
    // Completion, arbitration and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        busy        = (state_q != IDLE);
        timeout     = busy && !mem_ready && (wait_cnt_q == WAIT_LAST);
        done        = busy && (mem_ready || timeout);

        // In IDLE both requesters compete. On completion only the other
        // requester is eligible: the completing one's req is still high for
        // this cycle and must not re-grant it.
        cand_if     = if_req && ((state_q == IDLE) || (done && state_q == BUSY_DM));
        cand_dm     = dm_req && ((state_q == IDLE) || (done && state_q == BUSY_IF));

`ifdef ARB_RR_EN
        tie_dm      = !last_dm_q;
`else
        tie_dm      = 1'b1;
`endif
        grant_dm    = cand_dm && (!cand_if || tie_dm);
        grant_if    = cand_if && !grant_dm;

        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (busy && !done) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        if (grant_dm) begin
            state_d     = BUSY_DM;
            wait_cnt_d  = 8'd0;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
        end else if (grant_if) begin
            state_d     = BUSY_IF;
            wait_cnt_d  = 8'd0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
        end else if (done) begin
            state_d     = IDLE;
            wait_cnt_d  = 8'd0;
            mem_we_d    = 1'b0;
        end

`ifdef ARB_RR_EN
        last_dm_d = last_dm_q;
        if (grant_dm) begin
            last_dm_d = 1'b1;
        end else if (grant_if) begin
            last_dm_d = 1'b0;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dm_q <= 1'b0;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        mem_req   = busy;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;

        if_valid  = done && (state_q == BUSY_IF);
        dm_valid  = done && (state_q == BUSY_DM);
        err       = timeout;

        // Read data is forwarded only on a genuine completion; an aborted
        // transaction returns zero.
        if_rdata  = (if_valid && !timeout) ? mem_rdata : '0;
        dm_rdata  = (dm_valid && !timeout) ? mem_rdata : '0;

        StallF    = if_req && !if_valid;
        StallM    = dm_req && !dm_valid;
    end

endmodule
